// File: rtl/magia_stdio_line_arbiter_if.sv
// Handshake bundle between the per-tile print peripherals, the line arbiter and the
// mesh-level stdio sink.
//   in_valid/in_data/in_ready : per-tile byte push (tile t owns in_data[8t+7:8t])
//   out_valid/out_data/out_tile/out_last/out_ready : single merged byte stream
//   pending/busy              : status (tile has a locked line / arbiter draining)
// Modport slave is the arbiter; modport master is the surrounding environment.
interface magia_stdio_line_arbiter_if #(
  parameter int unsigned N_TILES = 4
);
  localparam int unsigned ID_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  logic [N_TILES-1:0]   in_valid;
  logic [N_TILES*8-1:0] in_data;
  logic [N_TILES-1:0]   in_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic [ID_W-1:0]      out_tile;
  logic                 out_last;
  logic                 out_ready;
  logic [N_TILES-1:0]   pending;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_tile, out_last, pending, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_tile, out_last, pending, busy
  );
endinterface

// File: rtl/magia_stdio_line_arbiter.sv
// Shares one byte-wide stdio stream among N_TILES print requesters. Each tile fills a
// private line buffer; a line is locked on newline (8'h0A) or when the buffer fills,
// then locked lines are granted round-robin and drained atomically so output lines
// from different tiles never interleave.
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active HIGH (legacy name kept from the codebase)
//   bus   : magia_stdio_line_arbiter_if.slave (byte inputs, merged output, status)
module magia_stdio_line_arbiter #(
  parameter int unsigned N_TILES  = 4,
  parameter int unsigned LINE_LEN = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  magia_stdio_line_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int unsigned CNT_W = $clog2(LINE_LEN + 1);
  localparam int unsigned PTR_W = $clog2(LINE_LEN);

  typedef enum logic {StIdle, StDrain} state_e;

  logic [7:0]         line_buf_q [N_TILES][LINE_LEN];
  logic [CNT_W-1:0]   count_q    [N_TILES];
  logic [N_TILES-1:0] pending_q;
  logic [N_TILES-1:0] accept;

  state_e           state_q;
  logic [ID_W-1:0]  grant_q;
  logic [ID_W-1:0]  last_grant_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] rd_nxt;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;
  logic             busy_q;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W:0]    scan;
  logic             drain_done;

  // A locked tile stalls until its line has fully left the arbiter.
  assign accept     = bus.in_valid & ~pending_q;
  assign drain_done = (state_q == StDrain) && bus.out_ready && out_last_q;
  assign rd_nxt     = rd_ptr_q + 1'b1;

  assign bus.in_ready  = ~pending_q;
  assign bus.pending   = pending_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tile  = grant_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

  // Round-robin pick starting just after the last granted tile. Scanning from the far
  // end down lets the nearest pending tile overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan       = '0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      scan = (ID_W + 1)'(last_grant_q) + (ID_W + 1)'(1) + (ID_W + 1)'(i);
      if (scan >= (ID_W + 1)'(N_TILES)) begin
        scan = scan - (ID_W + 1)'(N_TILES);
      end
      if (pending_q[scan[ID_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = scan[ID_W-1:0];
      end
    end
  end

  // Line storage carries no reset: only bytes below count are ever read.
  always_ff @(posedge clk) begin
    for (int t = 0; t < N_TILES; t++) begin
      if (accept[t]) begin
        line_buf_q[t][count_q[t][PTR_W-1:0]] <= bus.in_data[8*t +: 8];
      end
    end
  end

  // Per-tile fill level and line lock.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q   <= '{default: '0};
      pending_q <= '0;
    end else begin
      for (int t = 0; t < N_TILES; t++) begin
        if (drain_done && (grant_q == ID_W'(t))) begin
          count_q[t]   <= '0;
          pending_q[t] <= 1'b0;
        end else if (accept[t]) begin
          count_q[t] <= count_q[t] + 1'b1;
          if ((bus.in_data[8*t +: 8] == 8'h0A) || (count_q[t] == CNT_W'(LINE_LEN - 1))) begin
            pending_q[t] <= 1'b1;
          end
        end
      end
    end
  end

  // Grant/drain FSM. Output byte and last flag are preloaded one step ahead so they
  // come straight from flops and stay put while the sink stalls.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_TILES - 1);
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q     <= pick_id;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= line_buf_q[pick_id][PTR_W'(0)];
            out_last_q  <= (count_q[pick_id] == CNT_W'(1));
            busy_q      <= 1'b1;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              busy_q       <= 1'b0;
              last_grant_q <= grant_q;
              state_q      <= StIdle;
            end else begin
              rd_ptr_q   <= rd_nxt;
              out_data_q <= line_buf_q[grant_q][rd_nxt[PTR_W-1:0]];
              out_last_q <= ((rd_nxt + 1'b1) == count_q[grant_q]);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_magia_stdio_line_arbiter.sv
module tb_magia_stdio_line_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned L = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  magia_stdio_line_arbiter_if #(.N_TILES(N)) bus ();

  magia_stdio_line_arbiter #(.N_TILES(N), .LINE_LEN(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // cur: bytes accepted for a tile's open line. line: the locked line waiting for or
  // in output; the monitor pops its front each time the sink takes a byte.
  logic [7:0] cur  [N][$];
  logic [7:0] line [N][$];
  bit         locked [N];
  int         m_last;
  bit         m_drain;
  int         m_tile;
  int         lines_out;

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      cur[t].delete();
      line[t].delete();
      locked[t] = 0;
    end
    m_last  = N - 1;
    m_drain = 0;
    m_tile  = 0;
  endtask

  task automatic model_step();
    bit snap [N];
    logic [7:0] b;
    for (int t = 0; t < N; t++) snap[t] = locked[t];
    // DUT view after the last edge must match the model's view.
    for (int t = 0; t < N; t++) begin
      check($sformatf("in_ready[%0d]", t), 32'(bus.in_ready[t]), 32'(!snap[t]));
      check($sformatf("pending[%0d]", t), 32'(bus.pending[t]), 32'(snap[t]));
    end
    check("out_valid", 32'(bus.out_valid), 32'(m_drain));
    check("busy", 32'(bus.busy), 32'(m_drain));
    if (m_drain) begin
      check("out_tile", 32'(bus.out_tile), 32'(m_tile));
      check("out_data", 32'(bus.out_data), 32'(line[m_tile][0]));
      check("out_last", 32'(bus.out_last), 32'(line[m_tile].size() == 1));
    end
    // Effects of the coming edge.
    if (m_drain) begin
      if (bus.out_ready) begin
        void'(line[m_tile].pop_front());
        if (line[m_tile].size() == 0) begin
          locked[m_tile] = 0;
          m_last  = m_tile;
          m_drain = 0;
          lines_out++;
        end
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        int t;
        t = (m_last + i) % N;
        if (snap[t]) begin
          m_tile  = t;
          m_drain = 1;
          break;
        end
      end
    end
    for (int t = 0; t < N; t++) begin
      if (bus.in_valid[t] && !snap[t]) begin
        b = bus.in_data[8*t +: 8];
        cur[t].push_back(b);
        if (b == 8'h0A || cur[t].size() == L) begin
          line[t] = cur[t];
          cur[t].delete();
          locked[t] = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) model_reset();
    else model_step();
  end

  // ---------------- sink ready ----------------
  bit rdy_rand = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- drivers ----------------
  logic [7:0] dq [N][$];
  int         dly [N];

  task automatic push_str(input int t, input string s);
    for (int i = 0; i < s.len(); i++) dq[t].push_back(8'(s[i]));
  endtask

  // Offers every queued byte, each tile independently, until all have been taken.
  task automatic drive(input int budget);
    int cyc = 0;
    bit any;
    logic [N-1:0]   v;
    logic [N*8-1:0] d;
    forever begin
      any = 0;
      v = '0;
      d = '0;
      for (int t = 0; t < N; t++) begin
        if (dq[t].size() > 0) begin
          any = 1;
          if (dly[t] == 0) begin
            v[t] = 1'b1;
            d[8*t +: 8] = dq[t][0];
          end
        end
      end
      if (!any) break;
      bus.in_valid = v;
      bus.in_data  = d;
      @(negedge clk);
      for (int t = 0; t < N; t++) begin
        if (v[t] && bus.in_ready[t]) void'(dq[t].pop_front());
        if (dly[t] > 0) dly[t]--;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > budget) begin
        fail_now("drive_accept");
        for (int t = 0; t < N; t++) dq[t].delete();
      end
    end
    bus.in_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    bit busy_m;
    forever begin
      busy_m = m_drain;
      for (int t = 0; t < N; t++) busy_m |= locked[t];
      if (!busy_m) break;
      @(posedge clk);
      #1;
      c++;
      if (c > budget) begin
        fail_now("drain_done");
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_tile", 32'(bus.out_tile), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int exp_lines;
    logic [N-1:0]   v;
    logic [N*8-1:0] d;
    for (int t = 0; t < N; t++) dly[t] = 0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    lines_out = 0;
    exp_lines = 0;
    model_reset();

    // "hi\n" from tile 1.
    do_reset();
    push_str(1, "hi\n");
    drive(100);
    wait_idle(100);
    exp_lines += 1;

    // All four tiles lock "A\n" together; round-robin from tile 0.
    do_reset();
    for (int t = 0; t < N; t++) push_str(t, "A\n");
    drive(100);
    wait_idle(200);
    exp_lines += 4;

    // Full buffer on tile 2 with no newline.
    for (int i = 0; i < L; i++) dq[2].push_back(8'h41);
    drive(100);
    wait_idle(200);
    exp_lines += 1;

    // Stalling sink during a 5-byte line.
    rdy_rand = 1;
    push_str(1, "abcd\n");
    drive(100);
    wait_idle(300);
    exp_lines += 1;

    // Tile 3 writes while tile 0 drains; tile 0 relocks afterwards.
    push_str(0, "01234567\n");
    push_str(0, "q\n");
    push_str(3, "xyz\n");
    dly[3] = 12;
    drive(400);
    wait_idle(400);
    exp_lines += 3;
    rdy_rand = 0;
    check("line_count", 32'(lines_out), 32'(exp_lines));

    // Reset in the middle of a line: outputs drop immediately, line discarded.
    do_reset();
    push_str(1, "abc\n");
    push_str(2, "def\n");
    drive(100);
    c = 0;
    while (!bus.out_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!bus.out_valid) fail_now("drain_start");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_pending", 32'(bus.pending), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_out_last", 32'(bus.out_last), 0);
    check("midrst_out_data", 32'(bus.out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    push_str(2, "def\n");
    push_str(0, "ghi\n");
    drive(100);
    wait_idle(200);

    // Randomized traffic with a randomly stalling sink.
    rdy_rand = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v = '0;
      d = '0;
      for (int t = 0; t < N; t++) begin
        v[t] = ($urandom_range(0, 2) == 0);
        d[8*t +: 8] = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
      end
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      #1;
    end
    bus.in_valid = '0;
    // Close every open line (a lone newline where nothing is open).
    for (int t = 0; t < N; t++) push_str(t, "\n");
    drive(2000);
    wait_idle(3000);
    rdy_rand = 0;
    for (int t = 0; t < N; t++) begin
      check($sformatf("left_open[%0d]", t), 32'(cur[t].size()), 0);
      check($sformatf("left_locked[%0d]", t), 32'(locked[t]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
